serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial two's-complement adder for the datapath arithmetic library, complementing the half-subtractor cell (`HS_B`). It accepts two WIDTH-bit operands on a `start` pulse and adds them LSB-first, one bit per clock, through a single full-adder stage and a carry flip-flop. It reports the sum, carry-out and signed overflow with a one-cycle `done` strobe. It trades latency for area in the multi-cycle ALU path.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range is 2 to 32.

- `clk` input, 1 bit: the single clock; rising-edge active.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `start` input, 1 bit: request to begin an addition. Sampled only in IDLE.
- `a` input, WIDTH bits: operand A. Captured on the accepted `start` edge.
- `b` input, WIDTH bits: operand B. Captured on the accepted `start` edge.
- `busy` output, 1 bit: high while in RUN.
- `done` output, 1 bit: one-cycle strobe indicating the result is valid.
- `sum` output, WIDTH bits: registered result, equal to (a + b) mod 2^WIDTH.
- `cout` output, 1 bit: carry out of the MSB.
- `ovf` output, 1 bit: signed overflow, defined as (carry into MSB) XOR (carry out of MSB).

## Operation
- **States:** the FSM has three states, IDLE, RUN and DONE. Encoding is free.
- **IDLE:**
  - If `start`=1 at a rising edge: load `a` and `b` into the shift registers `a_sh` and `b_sh`, clear the carry flip-flop, clear the bit counter `cnt`, and go to RUN.
  - Otherwise remain in IDLE.
- **RUN, each edge:**
  - s_bit = `a_sh[0]` ^ `b_sh[0]` ^ c.
  - c ← majority(`a_sh[0]`, `b_sh[0]`, c).
  - Shift `a_sh` and `b_sh` right by one.
  - Shift the partial-sum register right, inserting s_bit at the MSB.
  - `cnt` ← `cnt` + 1.
  - `cnt` is ceil(log2(WIDTH+1)) bits wide. No wrap occurs, because `cnt` is only compared against WIDTH-1.
- **RUN, the edge where `cnt` == WIDTH-1 (the final bit):**
  - Record the carry-in to the MSB (the current c) as `c_msb`.
  - Load `sum` with the completed partial-sum register, including this bit.
  - Load `cout` with the new carry.
  - Load `ovf` with `c_msb` XOR the new carry.
  - Go to DONE.
- **DONE:** `done`=1 for exactly one cycle, then go to IDLE unconditionally.
- **`start` outside IDLE:** ignored in RUN and in DONE. It is not queued. The operand inputs may change freely after the accepting edge.
- **Result hold:** `sum`, `cout` and `ovf` hold their values until the next completion or reset. They do not change during a later RUN.
- **Reset:**
  - `rst`=1 at any time, including mid-RUN, immediately forces IDLE.
  - Reset clears `busy`, `done`, `sum`, `cout`, `ovf`, the shift registers, carry and `cnt` to 0.
  - No result is produced for an aborted operation.

## Timing
- **Reset values:** all outputs are 0 (`busy`=0, `done`=0, `sum`=0, `cout`=0, `ovf`=0).
- **Start to busy:** with `start` accepted at edge E0, `busy`=1 from edge E0 through edge E(WIDTH).
- **Busy to done:** at edge E(WIDTH), `busy` falls, `done` rises, and the results become valid.
- **Done width:** `done` falls at edge E(WIDTH+1).
- **Latency:** `done` asserts WIDTH cycles after the start edge.
- **Throughput:** the earliest next accepted `start` is edge E(WIDTH+2), giving one operation per WIDTH+2 cycles.
- **Output timing:** all outputs are registered; there is no combinational path from input to output.
- **`start` during reset release:** `start` held high while `rst` deasserts is accepted at the first rising edge with `rst`=0.

## Test plan
- **Basic add:** WIDTH=8, a=0x35, b=0x4A, single-cycle `start`.
  - Require `busy` high for 8 cycles.
  - Require `done` for 1 cycle at start+8.
  - Require `sum`=0x7F, `cout`=0, `ovf`=0.
- **Carry out:** a=0xFF, b=0x01 → `sum`=0x00, `cout`=1, `ovf`=0.
- **Signed overflow:**
  - a=0x7F, b=0x01 → `sum`=0x80, `cout`=0, `ovf`=1.
  - a=0x80, b=0x80 → `sum`=0x00, `cout`=1, `ovf`=1.
- **Ignored start:**
  - Pulse `start` with a=0x11, b=0x22 at cycle 3 of a running 0x01+0x02.
  - Require a single `done` with `sum`=0x03.
  - Require `busy` to fall exactly at start+8.
  - Require no second operation.
- **Reset mid-operation:**
  - Assert `rst` at cycle 4 of 0xFF+0x01.
  - Require all outputs to be 0 immediately, with no `done` afterwards.
  - Then run 0x10+0x20 and require `sum`=0x30.
- **Back-to-back:**
  - Hold `start` high continuously with fixed a=0x05, b=0x03.
  - Require `done` pulses every 10 cycles with `sum`=0x08.
  - Require `sum` to stay stable across each intervening RUN.

Source files
------------

// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder.
// The master drives the operands and start; the slave returns status and result.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial two's-complement adder: one full-adder stage plus a carry flop,
// LSB first, with sum/carry-out/signed-overflow held until the next completion.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] psum;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             s_bit;
  logic             carry_nxt;
  logic             last_bit;

  // Single full-adder stage on the current LSBs
  always_comb begin
    s_bit     = a_sh[0] ^ b_sh[0] ^ carry;
    carry_nxt = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    last_bit  = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last_bit)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status flags registered from the next state so they align with the state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.busy <= (state_nxt == RUN);
      bus.done <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      psum     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      bus.sum  <= '0;
      bus.cout <= 1'b0;
      bus.ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            carry <= 1'b0;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          psum  <= {s_bit, psum[WIDTH-1:1]};
          carry <= carry_nxt;
          cnt   <= cnt + CW'(1);
          // Current carry is the carry into the MSB on the final bit
          if (last_bit) begin
            bus.sum  <= {s_bit, psum[WIDTH-1:1]};
            bus.cout <= carry_nxt;
            bus.ovf  <= carry ^ carry_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed vectors, random operations,
// ignored start, reset abort and back-to-back throughput against an arithmetic model.
module tb_serial_adder;

  localparam int W = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {ovf, cout, sum} from plain integer addition and sign rules
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0]   full;
    logic [W-1:0] s;
    logic         o;
    full = {1'b0, x} + {1'b0, y};
    s    = full[W-1:0];
    o    = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
    return {o, full[W], s};
  endfunction

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.sum, bus.cout, bus.ovf} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
               bus.busy, bus.done, bus.sum, bus.cout, bus.ovf);
    end
    bus.start = 1'b1; bus.a = 8'h12; bus.b = 8'h34;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL start_at_reset_release: busy=%b want 1", bus.busy);
    end
    for (int k = 1; k <= W; k++) @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.sum !== 8'h46) begin
      errors++;
      $display("FAIL reset_release_result: done=%b sum=%h want done=1 sum=46", bus.done, bus.sum);
    end
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [W-1:0] va [4];
    logic [W-1:0] vb [4];
    logic [W+1:0] exp;
    va = '{8'h35, 8'hFF, 8'h7F, 8'h80};
    vb = '{8'h4A, 8'h01, 8'h01, 8'h80};
    for (int i = 0; i < 4; i++) begin
      exp = model(va[i], vb[i]);
      bus.start = 1'b1; bus.a = va[i]; bus.b = vb[i];
      @(negedge clk);
      bus.start = 1'b0;
      for (int k = 0; k <= W + 1; k++) begin
        if (k > 0) @(negedge clk);
        checks++;
        if (bus.busy !== (k < W) || bus.done !== (k == W)) begin
          errors++;
          $display("FAIL directed_timing[%0d] k=%0d: busy=%b done=%b want busy=%b done=%b",
                   i, k, bus.busy, bus.done, (k < W), (k == W));
        end
        if (k == W) begin
          checks++;
          if ({bus.ovf, bus.cout, bus.sum} !== exp) begin
            errors++;
            $display("FAIL directed_result[%0d] %h+%h: sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                     i, va[i], vb[i], bus.sum, bus.cout, bus.ovf, exp[W-1:0], exp[W], exp[W+1]);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W+1:0] exp;
    for (int i = 0; i < 25; i++) begin
      x = W'($urandom); y = W'($urandom);
      exp = model(x, y);
      bus.start = 1'b1; bus.a = x; bus.b = y;
      @(negedge clk);
      for (int k = 1; k <= W + 1; k++) begin
        // Noise on operands and start while running must be ignored
        bus.start = 1'($urandom_range(0, 1));
        bus.a = W'($urandom); bus.b = W'($urandom);
        @(negedge clk);
        if (k == W) begin
          checks++;
          if (bus.done !== 1'b1 || {bus.ovf, bus.cout, bus.sum} !== exp) begin
            errors++;
            $display("FAIL random_result[%0d] %h+%h: done=%b sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                     i, x, y, bus.done, bus.sum, bus.cout, bus.ovf, exp[W-1:0], exp[W], exp[W+1]);
          end
        end
      end
      bus.start = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL random_idle[%0d]: busy=%b done=%b want 0 0", i, bus.busy, bus.done);
      end
    end
  endtask

  task automatic test_ignored_start();
    int dones;
    dones = 0;
    bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h02;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= W + 12; k++) begin
      bus.start = (k == 3);
      if (k == 3) begin bus.a = 8'h11; bus.b = 8'h22; end
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) dones++;
      checks++;
      if (bus.busy !== (k < W)) begin
        errors++;
        $display("FAIL ignored_start_busy k=%0d: busy=%b want %b", k, bus.busy, (k < W));
      end
    end
    checks++;
    if (dones != 1 || bus.sum !== 8'h03) begin
      errors++;
      $display("FAIL ignored_start_result: dones=%0d sum=%h want 1 and 03", dones, bus.sum);
    end
  endtask

  task automatic test_reset_mid();
    int found;
    bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'h01;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.sum, bus.cout, bus.ovf} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
               bus.busy, bus.done, bus.sum, bus.cout, bus.ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_no_done k=%0d: done=%b busy=%b want 0 0", k, bus.done, bus.busy);
      end
    end
    bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h20;
    @(negedge clk);
    bus.start = 1'b0;
    found = 0;
    for (int k = 1; k <= W + 4 && found == 0; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) found = k;
    end
    checks++;
    if (found != W || bus.sum !== 8'h30) begin
      errors++;
      $display("FAIL reset_mid_rerun: done at cycle %0d sum=%h want cycle %0d sum=30", found, bus.sum, W);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic exp_done;
    bus.start = 1'b1; bus.a = 8'h05; bus.b = 8'h03;
    for (int k = 0; k < 4 * (W + 2); k++) begin
      @(negedge clk);
      exp_done = (k >= W) && ((k - W) % (W + 2) == 0);
      checks++;
      if (bus.done !== exp_done) begin
        errors++;
        $display("FAIL back_to_back_done k=%0d: done=%b want %b", k, bus.done, exp_done);
      end
      if (k >= W) begin
        checks++;
        if (bus.sum !== 8'h08) begin
          errors++;
          $display("FAIL back_to_back_sum k=%0d: sum=%h want 08", k, bus.sum);
        end
      end
    end
    bus.start = 1'b0;
    repeat (W + 2) @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    test_reset();
    test_directed();
    test_random();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
